// File: rtl/fire4_5_expand3_ofm_writer_pkg.sv
// Shared types and geometry for the fire4/fire5 expand-3x3 output writer.
// Default sizes match the fire4/fire5 layers of the network.
package fire_pkg;
  localparam int WIDTH     = 16;
  localparam int DSP_NO    = 128;
  localparam int WOUT      = 32;
  localparam int CH_TOTAL  = 256;
  localparam int CH_OFFSET = 128;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} wr_state_t;
  typedef logic [WIDTH-1:0] act_t;
endpackage

// File: rtl/fire4_5_expand3_ofm_writer.sv
// Snapshots one pixel of expand-3x3 outputs and writes it, one channel per cycle,
// into the concatenated fire output RAM; pulses ram_feedback_4/5 after the last pixel.
module fire4_5_expand3_ofm_writer
  import fire_pkg::*;
#(
  parameter int WIDTH     = fire_pkg::WIDTH,
  parameter int DSP_NO    = fire_pkg::DSP_NO,
  parameter int WOUT      = fire_pkg::WOUT,
  parameter int CH_TOTAL  = fire_pkg::CH_TOTAL,
  parameter int CH_OFFSET = fire_pkg::CH_OFFSET,
  parameter int ADDR_W    = $clog2(WOUT*WOUT*CH_TOTAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire4_expand_3_en,
  input  logic              fire5_expand_3_en,
  input  logic              fire4_expand_3_sample,
  input  logic [WIDTH-1:0]  ofm_2 [DSP_NO],
  input  logic [WIDTH-1:0]  ofm_3 [DSP_NO],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              ram_feedback_4,
  output logic              ram_feedback_5,
  output logic              overrun
);
  localparam int NPIX  = WOUT*WOUT;
  localparam int CH_W  = $clog2(DSP_NO);
  localparam int PIX_W = $clog2(NPIX);
  localparam int CH_SH = $clog2(CH_TOTAL);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(DSP_NO-1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX-1);

  wr_state_t        state;
  logic [CH_W-1:0]  ch_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic             layer_q;
  logic [WIDTH-1:0] snap [DSP_NO];
  logic             start;
  logic [CH_W-1:0]  ch_nxt;

  // CH_TOTAL is a power of two, so the pixel stride is a plain shift.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [PIX_W-1:0] p,
                                                  input logic [CH_W-1:0]  c);
    return (ADDR_W'(p) << CH_SH) + ADDR_W'(CH_OFFSET) + ADDR_W'(c);
  endfunction

  assign start  = (state == IDLE) && fire4_expand_3_sample &&
                  (fire4_expand_3_en || fire5_expand_3_en);
  assign ch_nxt = ch_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (start) begin
      for (int i = 0; i < DSP_NO; i++)
        snap[i] <= fire4_expand_3_en ? ofm_2[i] : ofm_3[i];
    end
  end

  // Word 0 is taken straight from the inputs so the first write lands one cycle after the sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ch_cnt         <= '0;
      pix_cnt        <= '0;
      layer_q        <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_feedback_4 <= 1'b0;
      ram_feedback_5 <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      ram_feedback_4 <= 1'b0;
      ram_feedback_5 <= 1'b0;
      if (fire4_expand_3_sample && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            layer_q   <= !fire4_expand_3_en;
            ch_cnt    <= '0;
            ram_we    <= 1'b1;
            ram_addr  <= slot_addr(pix_cnt, '0);
            ram_wdata <= fire4_expand_3_en ? ofm_2[0] : ofm_3[0];
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (ch_cnt == LAST_CH) begin
            ram_we <= 1'b0;
            ch_cnt <= '0;
            if (pix_cnt == LAST_PIX) begin
              ram_feedback_4 <= !layer_q;
              ram_feedback_5 <= layer_q;
              pix_cnt        <= '0;
              state          <= DONE;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
              state   <= IDLE;
            end
          end else begin
            ch_cnt    <= ch_nxt;
            ram_addr  <= slot_addr(pix_cnt, ch_nxt);
            ram_wdata <= snap[ch_nxt];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fire4_5_expand3_ofm_writer.sv
// Bench for the expand-3x3 OFM writer, built with an 8x8 map to keep layer runs short.
module tb_fire4_5_expand3_ofm_writer;
  import fire_pkg::*;

  localparam int W    = 16;
  localparam int N    = 128;
  localparam int WO   = 8;
  localparam int NPIX = WO*WO;
  localparam int CT   = 256;
  localparam int CO   = 128;
  localparam int AW   = $clog2(NPIX*CT);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en4 = 1'b0, en5 = 1'b0, smp = 1'b0;
  act_t          ofm_2 [N];
  act_t          ofm_3 [N];
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata;
  logic          fb4, fb5, overrun;

  fire4_5_expand3_ofm_writer #(.WOUT(WO)) dut (
    .clk(clk), .rst(rst),
    .fire4_expand_3_en(en4), .fire5_expand_3_en(en5), .fire4_expand_3_sample(smp),
    .ofm_2(ofm_2), .ofm_3(ofm_3),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_feedback_4(fb4), .ram_feedback_5(fb5), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
  typedef struct { int cyc; int layer; } fb_t;

  wr_t exp_q [$];
  fb_t fb_q  [$];
  wr_t e;
  fb_t f;
  int  checks = 0, errors = 0;
  int  wr_seen = 0, fb4_cnt = 0, fb5_cnt = 0;
  int  last_addr = -1;
  int  m_pix = 0, m_busy_until = -1;
  bit  m_ovr = 1'b0;

  // Scoreboard: every write and feedback pulse must match the reference queues in order and cycle.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_seen++;
      last_addr = int'(ram_addr);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h required=no write", cyc, ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        if (ram_addr !== e.addr || ram_wdata !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                   cyc, ram_addr, ram_wdata, e.cyc, e.addr, e.data);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      checks++; errors++;
      e = exp_q.pop_front();
      $display("FAIL missing_write cyc=%0d required addr=%0d at cyc=%0d", cyc, e.addr, e.cyc);
    end
    if (fb4 === 1'b1 || fb5 === 1'b1) begin
      if (fb4 === 1'b1) fb4_cnt++;
      if (fb5 === 1'b1) fb5_cnt++;
      checks++;
      if (fb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_feedback cyc=%0d fb4=%b fb5=%b required=none", cyc, fb4, fb5);
      end else begin
        f = fb_q.pop_front();
        if (cyc != f.cyc || fb4 !== (f.layer == 0) || fb5 !== (f.layer == 1)) begin
          errors++;
          $display("FAIL feedback cyc=%0d fb4=%b fb5=%b required cyc=%0d layer=%0d", cyc, fb4, fb5, f.cyc, f.layer);
        end
      end
    end else if (fb_q.size() != 0 && fb_q[0].cyc < cyc) begin
      checks++; errors++;
      f = fb_q.pop_front();
      $display("FAIL missing_feedback cyc=%0d required layer=%0d at cyc=%0d", cyc, f.layer, f.cyc);
    end
  end

  // Drive one sample during cycle c and update the reference model.
  task automatic sample_at(input int c, input bit e4, input bit e5,
                           input bit rnd, input int b2, input int b3);
    int s;
    do @(negedge clk); while (cyc < c);
    for (int i = 0; i < N; i++) begin
      ofm_2[i] = rnd ? W'($urandom) : W'(b2 + i);
      ofm_3[i] = rnd ? W'($urandom) : W'(b3 + i);
    end
    en4 = e4; en5 = e5; smp = 1'b1;
    s = cyc;
    if (s <= m_busy_until) begin
      m_ovr = 1'b1;
    end else if (e4 || e5) begin
      for (int i = 0; i < N; i++)
        exp_q.push_back('{cyc: s + 1 + i, addr: AW'(m_pix*CT + CO + i),
                          data: e4 ? ofm_2[i] : ofm_3[i]});
      if (m_pix == NPIX - 1) begin
        fb_q.push_back('{cyc: s + N + 1, layer: e4 ? 0 : 1});
        m_busy_until = s + N + 1;
        m_pix = 0;
      end else begin
        m_busy_until = s + N;
        m_pix++;
      end
    end
    @(posedge clk); #1;
    smp = 1'b0;
  endtask

  task automatic wait_drained();
    int t = 0;
    while ((exp_q.size() != 0 || fb_q.size() != 0) && t < 3000) begin
      @(negedge clk); t++;
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || fb_q.size() != 0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL drain_complete pending_writes=%0d pending_fb=%0d ram_we=%b required 0/0/0",
               exp_q.size(), fb_q.size(), ram_we);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    exp_q.delete(); fb_q.delete();
    m_pix = 0; m_busy_until = -1; m_ovr = 1'b0;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_wdata, fb4, fb5, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs we=%b addr=%0d data=%h fb4=%b fb5=%b ovr=%b required all 0",
               ram_we, ram_addr, ram_wdata, fb4, fb5, overrun);
    end
    repeat (2) @(negedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic check_overrun(input string name);
    #1;
    checks++;
    if (overrun !== m_ovr) begin
      errors++;
      $display("FAIL %s overrun=%b required=%b", name, overrun, m_ovr);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin ofm_2[i] = '0; ofm_3[i] = '0; end
    do_reset();
  endtask

  // Enables are dropped right after the sample; the drain must still complete.
  task automatic test_basic_drain();
    int w0 = wr_seen;
    sample_at(cyc + 2, 1'b1, 1'b0, 1'b0, 0, 16'h5000);
    en4 = 1'b0;
    wait_drained();
    checks++;
    if (wr_seen - w0 != N || last_addr != 255) begin
      errors++;
      $display("FAIL basic_drain writes=%0d last_addr=%0d required %0d/255", wr_seen - w0, last_addr, N);
    end
    check_overrun("basic_drain");
  endtask

  task automatic test_second_pixel();
    sample_at(cyc + 5, 1'b1, 1'b0, 1'b0, 16'h100, 16'h6000);
    wait_drained();
    checks++;
    if (last_addr != 511) begin
      errors++;
      $display("FAIL second_pixel last_addr=%0d required 511", last_addr);
    end
  endtask

  task automatic test_ignored_sample();
    int w0 = wr_seen;
    sample_at(cyc + 3, 1'b0, 1'b0, 1'b1, 0, 0);
    repeat (N + 10) @(negedge clk);
    checks++;
    if (wr_seen != w0) begin
      errors++;
      $display("FAIL ignored_sample writes=%0d required 0", wr_seen - w0);
    end
    check_overrun("ignored_sample");
  endtask

  task automatic test_layer(input bit first_both, input bit e4, input bit e5, input int b3,
                            input int want4, input int want5, input string name);
    int nxt = cyc + 2;
    int f4 = fb4_cnt, f5 = fb5_cnt;
    for (int p = 0; p < NPIX; p++) begin
      if (p == 0 && first_both) sample_at(nxt, 1'b1, 1'b1, 1'b0, 16'h1200, b3);
      else sample_at(nxt, e4, e5, (b3 == 0), 0, b3 + p);
      nxt = nxt + int'($urandom_range(130, 150));
    end
    wait_drained();
    checks++;
    if (last_addr != NPIX*CT - 1 || fb4_cnt - f4 != want4 || fb5_cnt - f5 != want5) begin
      errors++;
      $display("FAIL %s last_addr=%0d fb4=%0d fb5=%0d required %0d/%0d/%0d",
               name, last_addr, fb4_cnt - f4, fb5_cnt - f5, NPIX*CT - 1, want4, want5);
    end
    check_overrun(name);
  endtask

  task automatic test_overrun();
    int s, w0;
    do_reset();
    w0 = wr_seen;
    s = cyc + 2;
    sample_at(s, 1'b1, 1'b0, 1'b1, 0, 0);
    check_overrun("overrun_clear_before");
    sample_at(s + 50, 1'b1, 1'b0, 1'b1, 0, 0);
    repeat (2) @(negedge clk);
    check_overrun("overrun_set");
    wait_drained();
    repeat (20) @(negedge clk);
    check_overrun("overrun_sticky");
    checks++;
    if (wr_seen - w0 != N) begin
      errors++;
      $display("FAIL overrun_writes writes=%0d required %0d", wr_seen - w0, N);
    end
  endtask

  // A sample on the last write cycle is dropped; one cycle later it is accepted.
  task automatic test_overrun_boundary();
    int s;
    do_reset();
    s = cyc + 2;
    sample_at(s, 1'b0, 1'b1, 1'b1, 0, 0);
    sample_at(s + N, 1'b0, 1'b1, 1'b1, 0, 0);
    sample_at(s + N + 1, 1'b0, 1'b1, 1'b1, 0, 0);
    wait_drained();
    check_overrun("overrun_last_write");
    checks++;
    if (last_addr != CT + CO + N - 1) begin
      errors++;
      $display("FAIL boundary_accept last_addr=%0d required %0d", last_addr, CT + CO + N - 1);
    end
  endtask

  task automatic test_reset_mid_drain();
    int w0, t;
    do_reset();
    sample_at(cyc + 2, 1'b1, 1'b0, 1'b1, 0, 0);
    sample_at(cyc + N + 5, 1'b1, 1'b0, 1'b1, 0, 0);
    w0 = wr_seen; t = 0;
    while (wr_seen - w0 < 60 && t < 500) begin @(negedge clk); t++; end
    checks++;
    if (wr_seen - w0 < 60) begin
      errors++;
      $display("FAIL mid_drain_timeout writes=%0d required 60", wr_seen - w0);
    end
    do_reset();
    sample_at(cyc + 3, 1'b1, 1'b0, 1'b0, 16'h4400, 0);
    wait_drained();
    checks++;
    if (last_addr != CO + N - 1) begin
      errors++;
      $display("FAIL after_reset_pixel0 last_addr=%0d required %0d", last_addr, CO + N - 1);
    end
    check_overrun("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_second_pixel();
    test_ignored_sample();
    do_reset();
    test_layer(1'b0, 1'b1, 1'b0, 0, 1, 0, "fire4_layer");
    test_layer(1'b1, 1'b0, 1'b1, 16'hA000, 0, 1, "fire5_layer");
    test_overrun();
    test_overrun_boundary();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
